// File: rtl/serial_subtractor_pkg.sv
// Shared types and constants for the bit-serial subtractor.
// The optional OVF output is controlled by the SERIAL_SUBTRACTOR_OVF_EN macro.
package serial_subtractor_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        FIN   = 2'd2
    } state_t;

    localparam int WIDTH_DEFAULT = 8;

    // Bit counter only needs to reach WIDTH-1.
    function automatic int cnt_width(input int width);
        return (width > 1) ? $clog2(width) : 1;
    endfunction

endpackage

// File: rtl/serial_subtractor_half_sub.sv
// Combinational half subtractor: D = A - B with borrow out BO.
module Half_Subtractor (
    input  logic A,
    input  logic B,
    output logic D,
    output logic BO
);

    assign D  = A ^ B;
    assign BO = ~A & B;

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor D = A - B, LSB first, one bit per clock.
// Define SERIAL_SUBTRACTOR_OVF_EN to add the signed-overflow output OVF.
module serial_subtractor
    import serial_subtractor_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             START,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             BUSY,
    output logic             DONE,
    output logic [WIDTH-1:0] D,
`ifdef SERIAL_SUBTRACTOR_OVF_EN
    output logic             OVF,
`endif
    output logic             BOUT
);

    localparam int CW = cnt_width(WIDTH);
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] sa_q, sa_d;
    logic [WIDTH-1:0] sb_q, sb_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [WIDTH-1:0] dout_q, dout_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             bw_q, bw_d;
    logic             bout_q, bout_d;
    logic             done_q, done_d;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
    logic             am_q, am_d;
    logic             bm_q, bm_d;
    logic             ovf_q, ovf_d;
`endif

    logic hs1_d, hs1_bo, diff_bit, hs2_bo, bw_next;

    // Full-subtractor bit cell: two half subtractors, borrows ORed.
    Half_Subtractor u_hs1 (
        .A  (sa_q[0]),
        .B  (sb_q[0]),
        .D  (hs1_d),
        .BO (hs1_bo)
    );

    Half_Subtractor u_hs2 (
        .A  (hs1_d),
        .B  (bw_q),
        .D  (diff_bit),
        .BO (hs2_bo)
    );

    assign bw_next = hs1_bo | hs2_bo;

    always_comb begin
        state_d = state_q;
        sa_d    = sa_q;
        sb_d    = sb_q;
        res_d   = res_q;
        bw_d    = bw_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        dout_d  = dout_q;
        bout_d  = bout_q;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
        am_d    = am_q;
        bm_d    = bm_q;
        ovf_d   = ovf_q;
`endif
        case (state_q)
            IDLE: begin
                if (START) begin
                    sa_d    = A;
                    sb_d    = B;
                    res_d   = '0;
                    bw_d    = 1'b0;
                    cnt_d   = '0;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
                    am_d    = A[WIDTH-1];
                    bm_d    = B[WIDTH-1];
`endif
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                sa_d  = {1'b0, sa_q[WIDTH-1:1]};
                sb_d  = {1'b0, sb_q[WIDTH-1:1]};
                res_d = {diff_bit, res_q[WIDTH-1:1]};
                bw_d  = bw_next;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == LAST_BIT) begin
                    state_d = FIN;
                end
            end
            FIN: begin
                // Result registers load here so DONE and D appear together.
                done_d  = 1'b1;
                dout_d  = res_q;
                bout_d  = bw_q;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
                ovf_d   = (am_q ^ bm_q) & (am_q ^ res_q[WIDTH-1]);
`endif
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= IDLE;
            sa_q    <= '0;
            sb_q    <= '0;
            res_q   <= '0;
            bw_q    <= 1'b0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
            dout_q  <= '0;
            bout_q  <= 1'b0;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
            am_q    <= 1'b0;
            bm_q    <= 1'b0;
            ovf_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            sa_q    <= sa_d;
            sb_q    <= sb_d;
            res_q   <= res_d;
            bw_q    <= bw_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
            dout_q  <= dout_d;
            bout_q  <= bout_d;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
            am_q    <= am_d;
            bm_q    <= bm_d;
            ovf_q   <= ovf_d;
`endif
        end
    end

    assign BUSY = (state_q != IDLE);
    assign DONE = done_q;
    assign D    = dout_q;
    assign BOUT = bout_q;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
    assign OVF  = ovf_q;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed self-checking bench for serial_subtractor (WIDTH=8).
module tb_serial_subtractor;

    localparam int W = 8;

    logic         CLK = 1'b0;
    logic         RST;
    logic         START;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic         BUSY;
    logic         DONE;
    logic [W-1:0] D;
    logic         BOUT;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
    logic         OVF;
`endif

    int nChecks = 0;
    int nFails  = 0;

    always #5 CLK = ~CLK;

    serial_subtractor #(.WIDTH(W)) dut (
        .CLK   (CLK),
        .RST   (RST),
        .START (START),
        .A     (A),
        .B     (B),
        .BUSY  (BUSY),
        .DONE  (DONE),
        .D     (D),
`ifdef SERIAL_SUBTRACTOR_OVF_EN
        .OVF   (OVF),
`endif
        .BOUT  (BOUT)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        nChecks++;
        if (observed !== expected) begin
            nFails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Pulses START for one cycle; returns at the first negedge after acceptance
    // with the operand inputs scrambled.
    task automatic applyStimulus(input logic [W-1:0] a, input logic [W-1:0] b);
        @(negedge CLK);
        A     = a;
        B     = b;
        START = 1'b1;
        @(negedge CLK);
        START = 1'b0;
        A     = ~a;
        B     = ~b;
    endtask

    // Waits for DONE starting from cycle startLat after acceptance.
    task automatic waitDone(input string tag, input int startLat, output int lat);
        lat = 0;
        for (int i = startLat + 1; i <= startLat + 30; i++) begin
            @(negedge CLK);
            if (DONE === 1'b1) begin
                lat = i;
                break;
            end
        end
        if (lat == 0) checkOutput({tag, " done timeout"}, 32'd0, 32'd1);
    endtask

    task automatic runOp(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] expD, input logic expB);
        int lat;
        applyStimulus(a, b);
        checkOutput({tag, " busy"}, 32'(BUSY), 32'd1);
        waitDone(tag, 0, lat);
        checkOutput({tag, " latency"}, 32'(lat), 32'd9);
        checkOutput({tag, " D"}, 32'(D), 32'(expD));
        checkOutput({tag, " BOUT"}, 32'(BOUT), 32'(expB));
        @(negedge CLK);
        checkOutput({tag, " done pulse"}, 32'(DONE), 32'd0);
        @(negedge CLK);
        checkOutput({tag, " D hold"}, 32'(D), 32'(expD));
    endtask

    initial begin
        int lat;
        int extra;
        int first;
        int second;

        RST   = 1'b1;
        START = 1'b0;
        A     = '0;
        B     = '0;
        #12;
        checkOutput("reset BUSY", 32'(BUSY), 32'd0);
        checkOutput("reset DONE", 32'(DONE), 32'd0);
        checkOutput("reset D", 32'(D), 32'd0);
        checkOutput("reset BOUT", 32'(BOUT), 32'd0);
        @(negedge CLK);
        RST = 1'b0;

        runOp("5-3", 8'h05, 8'h03, 8'h02, 1'b0);
        runOp("3-5", 8'h03, 8'h05, 8'hFE, 1'b1);
        runOp("0-FF", 8'h00, 8'hFF, 8'h01, 1'b1);
        runOp("AA-AA", 8'hAA, 8'hAA, 8'h00, 1'b0);

        // START during an operation is dropped.
        applyStimulus(8'h20, 8'h07);
        repeat (3) @(negedge CLK);
        A     = 8'h10;
        B     = 8'h01;
        START = 1'b1;
        @(negedge CLK);
        START = 1'b0;
        waitDone("ignore", 4, lat);
        checkOutput("ignore latency", 32'(lat), 32'd9);
        checkOutput("ignore D", 32'(D), 32'h19);
        checkOutput("ignore BOUT", 32'(BOUT), 32'd0);
        extra = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge CLK);
            if (DONE === 1'b1) extra++;
        end
        checkOutput("ignore extra done", 32'(extra), 32'd0);
        checkOutput("ignore idle", 32'(BUSY), 32'd0);

        // Asynchronous reset mid-shift at count 4.
        applyStimulus(8'h33, 8'h11);
        repeat (4) @(negedge CLK);
        checkOutput("abort busy before", 32'(BUSY), 32'd1);
        #2 RST = 1'b1;
        #1;
        checkOutput("abort BUSY", 32'(BUSY), 32'd0);
        checkOutput("abort D", 32'(D), 32'd0);
        checkOutput("abort BOUT", 32'(BOUT), 32'd0);
        #1 RST = 1'b0;
        extra = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge CLK);
            if (DONE === 1'b1) extra++;
        end
        checkOutput("abort no done", 32'(extra), 32'd0);
        runOp("after abort", 8'h05, 8'h03, 8'h02, 1'b0);

        // START held high across two operations.
        @(negedge CLK);
        A      = 8'h09;
        B      = 8'h04;
        START  = 1'b1;
        first  = -1;
        second = -1;
        for (int i = 1; i <= 40; i++) begin
            @(negedge CLK);
            if (DONE === 1'b1) begin
                if (first < 0) begin
                    first = i;
                    checkOutput("held D first", 32'(D), 32'h05);
                end else begin
                    second = i;
                    checkOutput("held D second", 32'(D), 32'h05);
                    START = 1'b0;
                    break;
                end
            end
        end
        START = 1'b0;
        checkOutput("held first latency", 32'(first), 32'd10);
        checkOutput("held spacing", 32'(second - first), 32'(W + 2));
        @(negedge CLK);
        checkOutput("held idle", 32'(BUSY), 32'd0);

`ifdef SERIAL_SUBTRACTOR_OVF_EN
        runOp("ovf 80-01", 8'h80, 8'h01, 8'h7F, 1'b0);
        checkOutput("ovf 80-01 OVF", 32'(OVF), 32'd1);
        runOp("ovf 7F-FF", 8'h7F, 8'hFF, 8'h80, 1'b1);
        checkOutput("ovf 7F-FF OVF", 32'(OVF), 32'd1);
        runOp("ovf 05-03", 8'h05, 8'h03, 8'h02, 1'b0);
        checkOutput("ovf 05-03 OVF", 32'(OVF), 32'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", nChecks, nFails);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
